serial_frame_transmitter: RTL and testbench

//  Transmit side of the serial sequence-detector link: builds one frame per request and

---
 rtl/serial_frame_transmitter.sv | 127 ++++++++++++
 tb/tb_serial_frame_transmitter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_transmitter.sv
// serial_frame_transmitter
// Builds one frame per request (SYNC pattern, CNT_W-bit length N, N payload bits)
// and shifts it out on serOut, one bit per clkEn period. All outputs registered.
module serial_frame_transmitter #(
    parameter int                  SYNC_LEN     = 4,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 4'b1101,
    parameter int                  CNT_W        = 4,
    parameter int                  DATA_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clkEn,
    input  logic              start,
    input  logic [CNT_W-1:0]  countIn,
    input  logic [DATA_W-1:0] dataIn,
    output logic              serOut,
    output logic              busy,
    output logic              done
);

    localparam int MAXB  = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
    localparam int IDX_W = $clog2(MAXB + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_LEN,
        S_DATA
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [SYNC_LEN-1:0] r_syncSh;
    logic [CNT_W-1:0]    r_count;
    logic [CNT_W-1:0]    r_lenSh;
    logic [DATA_W-1:0]   r_dataSh;
    logic                r_serOut;
    logic                r_busy;
    logic                r_done;

    // Frame sequencer: each shift register holds the bits still to be sent after
    // the one currently on serOut, so every transition loads the next bit directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_syncSh <= '0;
            r_count  <= '0;
            r_lenSh  <= '0;
            r_dataSh <= '0;
            r_serOut <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_count  <= countIn;
                        r_dataSh <= dataIn;
                        r_syncSh <= SYNC_PATTERN << 1;
                        r_serOut <= SYNC_PATTERN[SYNC_LEN-1];
                        r_busy   <= 1'b1;
                        r_idx    <= '0;
                        r_state  <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    if (clkEn) begin
                        if (r_idx == IDX_W'(SYNC_LEN - 1)) begin
                            r_state  <= S_LEN;
                            r_idx    <= '0;
                            r_serOut <= r_count[CNT_W-1];
                            r_lenSh  <= r_count << 1;
                        end else begin
                            r_idx    <= r_idx + IDX_W'(1);
                            r_serOut <= r_syncSh[SYNC_LEN-1];
                            r_syncSh <= r_syncSh << 1;
                        end
                    end
                end
                S_LEN: begin
                    if (clkEn) begin
                        if (r_idx == IDX_W'(CNT_W - 1)) begin
                            r_idx <= '0;
                            if (r_count == '0) begin
                                r_serOut <= 1'b0;
                                r_busy   <= 1'b0;
                                r_done   <= 1'b1;
                                r_state  <= S_IDLE;
                            end else begin
                                r_state  <= S_DATA;
                                r_serOut <= r_dataSh[0];
                                r_dataSh <= r_dataSh >> 1;
                            end
                        end else begin
                            r_idx    <= r_idx + IDX_W'(1);
                            r_serOut <= r_lenSh[CNT_W-1];
                            r_lenSh  <= r_lenSh << 1;
                        end
                    end
                end
                S_DATA: begin
                    if (clkEn) begin
                        if (r_idx == IDX_W'(r_count - 1'b1)) begin
                            r_idx    <= '0;
                            r_serOut <= 1'b0;
                            r_busy   <= 1'b0;
                            r_done   <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_idx    <= r_idx + IDX_W'(1);
                            r_serOut <= r_dataSh[0];
                            r_dataSh <= r_dataSh >> 1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign serOut = r_serOut;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_serial_frame_transmitter.sv
// Self-checking bench for serial_frame_transmitter: expected line bits are queued
// when a frame is requested and compared against serOut every cycle of each period.
module tb_serial_frame_transmitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clkEn = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  countIn = '0;
    logic [15:0] dataIn = '0;
    logic        serOut;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    bit q[$];

    serial_frame_transmitter #(
        .SYNC_LEN    (4),
        .SYNC_PATTERN(4'b1101),
        .CNT_W       (4),
        .DATA_W      (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clkEn  (clkEn),
        .start  (start),
        .countIn(countIn),
        .dataIn (dataIn),
        .serOut (serOut),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    // Runs one frame starting at a negedge, ends at a negedge.
    // period: clkEn high once every 'period' cycles. restart_at/stall_at/abort_at
    // are bit-period indices (-1 disables). hold_end keeps start high over completion.
    task automatic send_frame(input logic [3:0] n, input logic [15:0] d, input int period,
                              input int restart_at, input int stall_at, input int abort_at,
                              input bit hold_end);
        int  pops = 0;
        int  cyc = 0;
        int  stall_left = 0;
        bit  stalled = 0;
        bit  en;
        q.delete();
        q.push_back(1); q.push_back(1); q.push_back(0); q.push_back(1);
        for (int i = 3; i >= 0; i--) q.push_back(n[i]);
        for (int i = 0; i < int'(n); i++) q.push_back(d[i]);
        countIn = n;
        dataIn  = d;
        start   = 1'b1;
        clkEn   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        countIn = 4'hA;
        dataIn  = 16'h5A5A;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL accept: busy=%b done=%b expected busy=1 done=0", busy, done);
        end
        while (q.size() > 0) begin
            if (cyc > 3000) begin
                checks++; errors++;
                $display("FAIL timeout: frame not finished, %0d bits left expected 0", q.size());
                q.delete();
                break;
            end
            if (abort_at >= 0 && pops == abort_at) begin
                #2 rst = 1'b1;
                #1;
                checks++;
                if (serOut !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL async_reset: serOut=%b busy=%b done=%b expected 0 0 0",
                             serOut, busy, done);
                end
                @(negedge clk);
                rst = 1'b0;
                clkEn = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    checks++;
                    if (serOut !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                        errors++;
                        $display("FAIL post_reset_idle: serOut=%b busy=%b done=%b expected 0 0 0",
                                 serOut, busy, done);
                    end
                end
                clkEn = 1'b0;
                q.delete();
                return;
            end
            checks++;
            if (serOut !== q[0] || busy !== 1'b1) begin
                errors++;
                $display("FAIL bit%0d: serOut=%b busy=%b expected serOut=%b busy=1",
                         pops, serOut, busy, q[0]);
            end
            en = ((cyc % period) == (period - 1));
            if (stall_at >= 0 && !stalled && pops == stall_at) begin
                stall_left = 5;
                stalled = 1;
            end
            if (stall_left > 0) begin
                en = 1'b0;
                stall_left--;
            end
            start = 1'b0;
            if (restart_at >= 0 && pops >= restart_at && pops < restart_at + 2) begin
                start = 1'b1;
                countIn = 4'd1;
                dataIn = 16'h0000;
            end
            if (hold_end && q.size() == 1 && en) start = 1'b1;
            if (en) begin
                void'(q.pop_front());
                pops++;
            end
            clkEn = en;
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (serOut !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
            errors++;
            $display("FAIL completion: serOut=%b busy=%b done=%b expected 0 0 1",
                     serOut, busy, done);
        end
        checks++;
        if (pops != 8 + int'(n)) begin
            errors++;
            $display("FAIL frame_len: periods=%0d expected %0d", pops, 8 + int'(n));
        end
        clkEn = 1'b0;
        if (!hold_end) begin
            start = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse: done=%b busy=%b expected 0 0", done, busy);
            end
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (serOut !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: serOut=%b busy=%b done=%b expected 0 0 0",
                     serOut, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        send_frame(4'd3, 16'h0005, 2, -1, -1, -1, 1'b0);
    endtask

    task automatic test_zero_len();
        send_frame(4'd0, 16'hFFFF, 2, -1, -1, -1, 1'b0);
    endtask

    task automatic test_max_len();
        send_frame(4'd15, 16'h7FFF, 1, -1, -1, -1, 1'b0);
    endtask

    task automatic test_restart_and_stall();
        send_frame(4'd6, 16'h002D, 3, 2, 10, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        send_frame(4'd4, 16'h000A, 2, -1, -1, 6, 1'b0);
        send_frame(4'd2, 16'h0003, 1, -1, -1, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        send_frame(4'd2, 16'h0002, 1, -1, -1, -1, 1'b1);
        send_frame(4'd5, 16'h0015, 2, -1, -1, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_max_len();
        test_restart_and_stall();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
